// File: rtl/resta_pkg.sv
// Shared types for the serial subtractor and the ALU control FSM that decodes
// its status.
package resta_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } estado_t;

endpackage : resta_pkg

// File: rtl/resta_posicion.sv
// One-bit full subtractor cell: resta = A - B - Bin, Bout = borrow out.
module resta_posicion (
  input  logic A,
  input  logic B,
  input  logic Bin,
  output logic resta,
  output logic Bout
);

  assign resta = A ^ B ^ Bin;
  assign Bout  = (~A & B) | (~(A ^ B) & Bin);

endmodule : resta_posicion

// File: rtl/resta_serial.sv
// Bit-serial N-bit subtractor computing A - B - BIN LSB first with a single
// full-subtractor cell, a borrow flop and a start/busy/done handshake.
module resta_serial
  import resta_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         BIN,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] diferencia,
  output logic         bout,
  output logic         overflow,
  output logic         zero
);

  localparam int            CW       = $clog2(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  estado_t       state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  a_q, a_d;
  logic [N-1:0]  b_q, b_d;
  logic [N-1:0]  dif_q, dif_d;
  logic          br_q, br_d;
  logic          a_msb_q, a_msb_d;
  logic          b_msb_q, b_msb_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          bout_q, bout_d;
  logic          ovf_q, ovf_d;
  logic          zero_q, zero_d;

  logic          bit_s;
  logic          borrow_s;
  logic [N-1:0]  dif_next_s;

  resta_posicion u_celda (
    .A    (a_q[0]),
    .B    (b_q[0]),
    .Bin  (br_q),
    .resta(bit_s),
    .Bout (borrow_s)
  );

  // New result bit enters at the MSB so that after N shifts bit 0 sits at LSB.
  assign dif_next_s = {bit_s, dif_q[N-1:1]};

  // Next-state, datapath and flag computation for the IDLE/RUN/DONE sequence.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    dif_d   = dif_q;
    br_d    = br_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          br_d    = BIN;
          a_msb_d = A[N-1];
          b_msb_d = B[N-1];
          cnt_d   = {CW{1'b0}};
          busy_d  = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end

      RUN: begin
        dif_d = dif_next_s;
        a_d   = {1'b0, a_q[N-1:1]};
        b_d   = {1'b0, b_q[N-1:1]};
        br_d  = borrow_s;
        if (cnt_q == CNT_LAST) begin
          // Flags are frozen here, from the final bit and the captured MSBs.
          cnt_d   = {CW{1'b0}};
          bout_d  = borrow_s;
          ovf_d   = (a_msb_q != b_msb_q) && (bit_s != a_msb_q);
          zero_d  = (dif_next_s == {N{1'b0}});
          busy_d  = 1'b0;
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q + CW'(1'b1);
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end

      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs; reset aborts any operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= {CW{1'b0}};
      a_q     <= {N{1'b0}};
      b_q     <= {N{1'b0}};
      dif_q   <= {N{1'b0}};
      br_q    <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      dif_q   <= dif_d;
      br_q    <= br_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign diferencia = dif_q;
  assign bout       = bout_q;
  assign overflow   = ovf_q;
  assign zero       = zero_q;

endmodule : resta_serial

// File: tb/tb_resta_serial.sv
// Self-checking bench: N=4 directed operations and an N=8 randomized sweep,
// both compared every cycle against an arithmetic reference model.
module tb_resta_serial;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       start4 = 1'b0, bin4 = 1'b0;
  logic [3:0] a4 = 4'd0, b4 = 4'd0;
  logic       busy4, done4, bout4, ovf4, zero4;
  logic [3:0] dif4;

  logic       start8 = 1'b0, bin8 = 1'b0;
  logic [7:0] a8 = 8'd0, b8 = 8'd0;
  logic       busy8, done8, bout8, ovf8, zero8;
  logic [7:0] dif8;

  always #5 clk = ~clk;

  resta_serial #(.N(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .A(a4), .B(b4), .BIN(bin4),
    .busy(busy4), .done(done4), .diferencia(dif4), .bout(bout4),
    .overflow(ovf4), .zero(zero4)
  );

  resta_serial #(.N(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .A(a8), .B(b8), .BIN(bin8),
    .busy(busy8), .done(done8), .diferencia(dif8), .bout(bout8),
    .overflow(ovf8), .zero(zero8)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc[2]   = '{-100, -100};
  int m_dif[2] = '{0, 0};
  int m_bo[2]  = '{0, 0};
  int m_ov[2]  = '{0, 0};
  int m_z[2]   = '{0, 0};
  int last_done = 0;
  int done8_cnt = 0;
  bit sweep = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int wd(input int i);
    return (i == 0) ? 4 : 8;
  endfunction
  function automatic int st(input int i);
    return (i == 0) ? int'(start4) : int'(start8);
  endfunction
  function automatic int opa(input int i);
    return (i == 0) ? int'(a4) : int'(a8);
  endfunction
  function automatic int opb(input int i);
    return (i == 0) ? int'(b4) : int'(b8);
  endfunction
  function automatic int opbin(input int i);
    return (i == 0) ? int'(bin4) : int'(bin8);
  endfunction
  function automatic int o_busy(input int i);
    return (i == 0) ? int'(busy4) : int'(busy8);
  endfunction
  function automatic int o_done(input int i);
    return (i == 0) ? int'(done4) : int'(done8);
  endfunction
  function automatic int o_dif(input int i);
    return (i == 0) ? int'(dif4) : int'(dif8);
  endfunction
  function automatic int o_bout(input int i);
    return (i == 0) ? int'(bout4) : int'(bout8);
  endfunction
  function automatic int o_ovf(input int i);
    return (i == 0) ? int'(ovf4) : int'(ovf8);
  endfunction
  function automatic int o_zero(input int i);
    return (i == 0) ? int'(zero4) : int'(zero8);
  endfunction

  // Reference arithmetic: unsigned difference for result/borrow, signed range for overflow.
  task automatic calc(input int n, input int a, input int b, input int bin,
                      output int d, output int bo, output int ov, output int z);
    int full, sa, sb, sd, half;
    half = 1 << (n - 1);
    full = a - b - bin;
    d    = full & ((1 << n) - 1);
    bo   = (full < 0) ? 1 : 0;
    sa   = (a >= half) ? a - (1 << n) : a;
    sb   = (b >= half) ? b - (1 << n) : b;
    sd   = sa - sb - bin;
    ov   = (sd < -half || sd > half - 1) ? 1 : 0;
    z    = (d == 0) ? 1 : 0;
  endtask

  // Model: an op is accepted at an edge when start is high and the previous one
  // accepted at least N+2 edges earlier; busy for N cycles, done N+1 edges later.
  always @(posedge clk) begin : model
    int c, e, d, bo, ov, z;
    c = cyc + 1;
    cyc <= c;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        acc[i] <= -100;
      end else begin
        e = c - acc[i];
        if (st(i) != 0 && e >= wd(i) + 2) begin
          calc(wd(i), opa(i), opb(i), opbin(i), d, bo, ov, z);
          acc[i]   <= c;
          m_dif[i] <= d;
          m_bo[i]  <= bo;
          m_ov[i]  <= ov;
          m_z[i]   <= z;
        end
      end
    end
  end

  // Every-cycle comparison of both DUTs against the model.
  always @(negedge clk) begin : compare
    int e, n;
    string p;
    if (!rst && cyc > 0) begin
      for (int i = 0; i < 2; i++) begin
        n = wd(i);
        e = cyc - acc[i];
        p = $sformatf("n%0d_", n);
        check({p, "busy"}, o_busy(i), (e >= 0 && e < n) ? 1 : 0);
        check({p, "done"}, o_done(i), (e == n + 1) ? 1 : 0);
        check({p, "busy_and_done"}, o_busy(i) & o_done(i), 0);
        if (acc[i] == -100) begin
          check({p, "dif_rst"}, o_dif(i), 0);
          check({p, "bout_rst"}, o_bout(i), 0);
          check({p, "ovf_rst"}, o_ovf(i), 0);
          check({p, "zero_rst"}, o_zero(i), 0);
        end else if (e >= n + 1) begin
          check({p, "dif"}, o_dif(i), m_dif[i]);
          check({p, "bout"}, o_bout(i), m_bo[i]);
          check({p, "ovf"}, o_ovf(i), m_ov[i]);
          check({p, "zero"}, o_zero(i), m_z[i]);
        end
      end
      if (sweep && done8 == 1'b1) begin
        if (last_done > 0) check("n8_done_spacing", cyc - last_done, 10);
        last_done <= cyc;
        done8_cnt <= done8_cnt + 1;
      end
    end
  end

  // Directed N=4 operation with literal expectations; ign>0 injects start pulses during RUN.
  task automatic do_op(input int a, input int b, input int bin, input int e_dif,
                       input int e_bo, input int e_ov, input int e_z, input int ign);
    int k, n, extra;
    @(negedge clk);
    a4 = 4'(a); b4 = 4'(b); bin4 = 1'(bin); start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    k = cyc;
    for (int j = 0; j < ign; j++) begin
      a4 = 4'($urandom); b4 = 4'($urandom); bin4 = 1'($urandom); start4 = 1'b1;
      @(negedge clk);
    end
    start4 = 1'b0;
    n = 0;
    while (done4 != 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("lit_latency", cyc - k, 5);
    check("lit_dif", int'(dif4), e_dif);
    check("lit_bout", int'(bout4), e_bo);
    if (e_ov >= 0) check("lit_ovf", int'(ovf4), e_ov);
    check("lit_zero", int'(zero4), e_z);
    if (ign > 0) begin
      extra = 0;
      repeat (8) begin
        @(negedge clk);
        if (done4 == 1'b1) extra++;
      end
      check("lit_extra_done", extra, 0);
    end
  endtask

  initial begin : stim
    int n, extra;
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy4), 0);
    check("rst_done", int'(done4), 0);
    check("rst_dif", int'(dif4), 0);
    check("rst_flags", int'({bout4, ovf4, zero4}), 0);
    #2 rst = 1'b0;
    @(negedge clk);

    do_op(9, 3, 0, 6, 0, -1, 0, 0);
    do_op(3, 9, 0, 10, 1, -1, 0, 0);
    do_op(7, 7, 0, 0, 0, 0, 1, 0);
    do_op(0, 0, 1, 15, 1, 0, 0, 0);
    do_op(8, 1, 0, 7, 0, 1, 0, 0);
    do_op(7, 15, 0, 8, 1, 1, 0, 0);
    do_op(9, 3, 0, 6, 0, -1, 0, 3);

    // Abort an operation with reset in its third RUN cycle.
    @(negedge clk);
    a4 = 4'd12; b4 = 4'd3; bin4 = 1'b0; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", int'(busy4), 0);
    check("abort_done", int'(done4), 0);
    check("abort_dif", int'(dif4), 0);
    check("abort_flags", int'({bout4, ovf4, zero4}), 0);
    @(negedge clk);
    #2 rst = 1'b0;
    extra = 0;
    repeat (8) begin
      @(negedge clk);
      if (done4 == 1'b1) extra++;
    end
    check("abort_no_done", extra, 0);
    do_op(5, 2, 0, 3, 0, 0, 0, 0);

    // N=8 sweep with start held high and fresh random operands every cycle.
    sweep = 1'b1;
    start8 = 1'b1;
    n = 0;
    while (done8_cnt < 1000 && n < 12000) begin
      a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
      @(negedge clk);
      n++;
    end
    check("sweep_ops_done", (done8_cnt >= 1000) ? 1 : 0, 1);
    start8 = 1'b0;
    repeat (12) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule : tb_resta_serial
